// File: rtl/fmul_hp_arbiter_pkg.sv
// Shared half-precision field widths, arbiter state encoding and the
// packed result layout used by the multiplier arbiter.
package fp_hp_pkg;
  localparam int unsigned HP_SIGN_W = 1;
  localparam int unsigned HP_EXP_W  = 5;
  localparam int unsigned HP_MANT_W = 10;
  localparam int unsigned HP_W      = 16;
  localparam int unsigned HP_BIAS   = 15;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } state_t;

  typedef struct packed {
    logic                 sign;
    logic [HP_EXP_W-1:0]  exp;
    logic [HP_MANT_W-1:0] mant;
  } hp_t;
endpackage

// File: rtl/fmul_hp_arbiter_if.sv
// Two-requester operand/result bus between FP clients and the arbiter.
interface fmul_hp_arbiter_if;
  import fp_hp_pkg::*;

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [2*HP_W-1:0] req_op_a;
  logic [2*HP_W-1:0] req_op_b;
  logic [1:0]        resp_valid;
  logic [1:0]        resp_ready;
  logic [HP_W-1:0]   resp_result;
  logic              resp_ovf;
  logic              busy;

  modport master (
    output req_valid, req_op_a, req_op_b, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_ovf, busy
  );

  modport slave (
    input  req_valid, req_op_a, req_op_b, resp_ready,
    output req_ready, resp_valid, resp_result, resp_ovf, busy
  );
endinterface

// File: rtl/fmul_hp_arbiter_fmul.sv
// Combinational half-precision multiplier: denormals flush to zero,
// round-to-nearest-even, saturates to infinity on exponent overflow.
module FMul_HalfPrecision
  import fp_hp_pkg::*;
(
  input  logic [HP_W-1:0]      A,
  input  logic [HP_W-1:0]      B,
  output logic                 Sign,
  output logic [HP_EXP_W-1:0]  Exponent,
  output logic [HP_MANT_W-1:0] Mantissa,
  output logic                 Exponent_Overflow
);
  logic [21:0] prod;
  logic [20:0] prod_n;
  logic        norm;
  logic        rnd;
  logic [10:0] mant_r;
  logic [6:0]  e_tmp;
  logic [6:0]  e_res;
  logic        zero;
  logic        uflow;

  always_comb begin
    Sign   = A[15] ^ B[15];
    zero   = (A[14:10] == '0) || (B[14:10] == '0);
    prod   = {11'b0, 1'b1, A[9:0]} * {11'b0, 1'b1, B[9:0]};
    norm   = prod[21];
    prod_n = norm ? prod[20:0] : {prod[19:0], 1'b0};
    // guard bit with sticky/lsb tie-break; a carry out bumps the exponent
    rnd    = prod_n[10] & ((|prod_n[9:0]) | prod_n[11]);
    mant_r = {1'b0, prod_n[20:11]} + {10'b0, rnd};
    e_tmp  = {2'b0, A[14:10]} + {2'b0, B[14:10]} + {6'b0, norm} + {6'b0, mant_r[10]};
    e_res  = e_tmp - 7'(HP_BIAS);
    uflow  = (e_tmp <= 7'(HP_BIAS));
    Exponent_Overflow = !zero && !uflow && (e_res >= 7'd31);
    Exponent = '0;
    Mantissa = '0;
    if (zero || uflow) begin
      Exponent = '0;
      Mantissa = '0;
    end else if (Exponent_Overflow) begin
      Exponent = '1;
      Mantissa = '0;
    end else begin
      Exponent = e_res[4:0];
      Mantissa = mant_r[9:0];
    end
  end
endmodule

// File: rtl/fmul_hp_arbiter.sv
// Two-way round-robin arbiter sharing one half-precision multiplier,
// valid/ready on both request and response sides, one op in flight.
module fmul_hp_arbiter
  import fp_hp_pkg::*;
#(
  parameter int unsigned CALC_CYCLES = 1
) (
  input logic               clk,
  input logic               rst_n,
  fmul_hp_arbiter_if.slave  bus
);
  localparam int unsigned CNT_W = (CALC_CYCLES > 1) ? $clog2(CALC_CYCLES) : 1;

  state_t          state;
  logic            prio;
  logic            owner;
  logic            busy_q;
  logic [CNT_W-1:0] calc_cnt;
  logic [HP_W-1:0] op_a_q;
  logic [HP_W-1:0] op_b_q;
  hp_t             result_q;
  logic            ovf_q;
  logic [1:0]      resp_valid_q;

  logic            gnt;
  logic            gnt_vld;
  logic [1:0]      req_ready;
  hp_t             prod;
  logic            prod_ovf;

  // ready is held low during reset even though the state already reads IDLE
  always_comb begin
    gnt       = prio;
    gnt_vld   = 1'b0;
    req_ready = '0;
    if (state == IDLE && rst_n) begin
      if (bus.req_valid[prio]) begin
        gnt     = prio;
        gnt_vld = 1'b1;
      end else if (bus.req_valid[~prio]) begin
        gnt     = ~prio;
        gnt_vld = 1'b1;
      end
    end
    if (gnt_vld) req_ready[gnt] = 1'b1;
  end

  FMul_HalfPrecision u_fmul (
    .A                 (op_a_q),
    .B                 (op_b_q),
    .Sign              (prod.sign),
    .Exponent          (prod.exp),
    .Mantissa          (prod.mant),
    .Exponent_Overflow (prod_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      prio         <= 1'b0;
      owner        <= 1'b0;
      busy_q       <= 1'b0;
      calc_cnt     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      result_q     <= '0;
      ovf_q        <= 1'b0;
      resp_valid_q <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_vld) begin
          op_a_q   <= gnt ? bus.req_op_a[2*HP_W-1:HP_W] : bus.req_op_a[HP_W-1:0];
          op_b_q   <= gnt ? bus.req_op_b[2*HP_W-1:HP_W] : bus.req_op_b[HP_W-1:0];
          owner    <= gnt;
          calc_cnt <= CNT_W'(CALC_CYCLES - 1);
          busy_q   <= 1'b1;
          state    <= CALC;
        end
        CALC: if (calc_cnt == '0) begin
          result_q     <= prod;
          ovf_q        <= prod_ovf;
          resp_valid_q <= owner ? 2'b10 : 2'b01;
          state        <= RESP;
        end else begin
          calc_cnt <= calc_cnt - CNT_W'(1);
        end
        RESP: if (bus.resp_ready[owner]) begin
          resp_valid_q <= '0;
          prio         <= ~owner;
          busy_q       <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = result_q;
  assign bus.resp_ovf    = ovf_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_fmul_hp_arbiter.sv
// Directed bench: reset, contention/round-robin, single op, backpressure,
// overflow, request drop and reset during a multicycle calculation.
module tb_fmul_hp_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  logic rst3_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fmul_hp_arbiter_if b1 ();
  fmul_hp_arbiter_if b3 ();

  fmul_hp_arbiter #(.CALC_CYCLES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b1.slave)
  );

  fmul_hp_arbiter #(.CALC_CYCLES(3)) dut3 (
    .clk   (clk),
    .rst_n (rst3_n),
    .bus   (b3.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    rst3_n = 1'b0;
    b1.req_valid  = 2'b11;
    b1.req_op_a   = {16'h4000, 16'h3C00};
    b1.req_op_b   = {16'h4000, 16'h4000};
    b1.resp_ready = 2'b00;
    b3.req_valid  = 2'b00;
    b3.req_op_a   = '0;
    b3.req_op_b   = '0;
    b3.resp_ready = 2'b00;

    // reset with both requesters valid
    repeat (3) tick;
    chk("rst_req_ready", b1.req_ready, 2'b00);
    chk("rst_resp_valid", b1.resp_valid, 2'b00);
    chk("rst_busy", b1.busy, 1'b0);
    chk("rst_result", b1.resp_result, 16'h0000);
    chk("rst_ovf", b1.resp_ovf, 1'b0);

    // contention from reset: req0 (prio) first
    rst_n  = 1'b1;
    rst3_n = 1'b1;
    #1;
    chk("cont_gnt0", b1.req_ready, 2'b01);
    tick;
    chk("cont_busy", b1.busy, 1'b1);
    chk("calc_ready_low", b1.req_ready, 2'b00);
    chk("calc_no_resp", b1.resp_valid, 2'b00);
    tick;
    chk("cont_resp0_valid", b1.resp_valid, 2'b01);
    chk("cont_resp0_result", b1.resp_result, 16'h4000);
    chk("cont_resp0_ovf", b1.resp_ovf, 1'b0);
    b1.resp_ready = 2'b01;
    tick;
    chk("cont_done0_valid", b1.resp_valid, 2'b00);
    chk("cont_done0_busy", b1.busy, 1'b0);
    chk("cont_gnt1", b1.req_ready, 2'b10);
    tick;
    tick;
    chk("cont_resp1_valid", b1.resp_valid, 2'b10);
    chk("cont_resp1_result", b1.resp_result, 16'h4400);
    tick;
    chk("nonowner_ready_ignored", b1.resp_valid, 2'b10);
    b1.resp_ready = 2'b11;
    tick;
    chk("cont_done1_busy", b1.busy, 1'b0);
    chk("reissue_gnt0", b1.req_ready, 2'b01);

    // single op from req0; operands change after accept
    b1.req_valid  = 2'b01;
    b1.req_op_a   = {16'h4000, 16'h3E00};
    b1.req_op_b   = {16'h4000, 16'hC000};
    b1.resp_ready = 2'b00;
    #1;
    chk("single_gnt0", b1.req_ready, 2'b01);
    tick;
    b1.req_op_a  = {16'hFFFF, 16'h7BFF};
    b1.req_op_b  = {16'hFFFF, 16'h7BFF};
    b1.req_valid = 2'b11;
    tick;
    chk("single_valid", b1.resp_valid, 2'b01);
    chk("single_result", b1.resp_result, 16'hC200);
    chk("single_ovf", b1.resp_ovf, 1'b0);

    // backpressure: response held, no new grants
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("bp_valid", b1.resp_valid, 2'b01);
      chk("bp_result", b1.resp_result, 16'hC200);
      chk("bp_req_ready", b1.req_ready, 2'b00);
    end
    b1.req_valid  = 2'b00;
    b1.resp_ready = 2'b01;
    tick;
    chk("bp_release_busy", b1.busy, 1'b0);
    chk("bp_release_valid", b1.resp_valid, 2'b00);
    chk("bp_result_hold", b1.resp_result, 16'hC200);

    // prio is now 1; non-priority request valid then dropped before the edge
    b1.req_valid = 2'b01;
    #1;
    chk("nonprio_gnt", b1.req_ready, 2'b01);
    b1.req_valid = 2'b00;
    #1;
    chk("drop_ready", b1.req_ready, 2'b00);
    tick;
    chk("drop_no_accept", b1.busy, 1'b0);

    // overflow, with resp_ready already high when resp_valid rises
    b1.req_valid = 2'b01;
    b1.req_op_a  = {16'h0000, 16'h7800};
    b1.req_op_b  = {16'h0000, 16'h7800};
    tick;
    b1.req_valid  = 2'b00;
    b1.resp_ready = 2'b01;
    tick;
    chk("ovf_valid", b1.resp_valid, 2'b01);
    chk("ovf_result", b1.resp_result, 16'h7C00);
    chk("ovf_flag", b1.resp_ovf, 1'b1);
    tick;
    chk("ovf_done_busy", b1.busy, 1'b0);
    chk("ovf_done_valid", b1.resp_valid, 2'b00);
    b1.req_valid = 2'b11;
    #1;
    chk("prio_after_nonprio", b1.req_ready, 2'b10);
    b1.req_valid = 2'b00;

    // CALC_CYCLES=3: reset mid-calculation discards the operation
    b3.req_valid = 2'b01;
    b3.req_op_a  = {16'h0000, 16'h3E00};
    b3.req_op_b  = {16'h0000, 16'hC000};
    tick;
    b3.req_valid = 2'b00;
    tick;
    chk("calc3_busy", b3.busy, 1'b1);
    #1;
    rst3_n = 1'b0;
    #1;
    chk("calc3_rst_busy", b3.busy, 1'b0);
    chk("calc3_rst_valid", b3.resp_valid, 2'b00);
    tick;
    rst3_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("calc3_no_resp", b3.resp_valid, 2'b00);
    end
    b3.req_valid = 2'b01;
    b3.req_op_a  = {16'h0000, 16'h3C00};
    b3.req_op_b  = {16'h0000, 16'h4000};
    #1;
    chk("calc3_gnt0", b3.req_ready, 2'b01);
    tick;
    b3.req_valid = 2'b00;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("calc3_wait", b3.resp_valid, 2'b00);
    end
    tick;
    chk("calc3_valid", b3.resp_valid, 2'b01);
    chk("calc3_result", b3.resp_result, 16'h4000);
    b3.resp_ready = 2'b01;
    tick;
    chk("calc3_done_busy", b3.busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
